// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: instruction field positions, NOP encoding,
// default reset PC and instruction memory geometry. MainControl imports this too.
package instruction_fetch_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned DefaultImemDepth = 128;
  localparam word_t       DefaultResetPc   = 32'h0000_0000;
  // Word index is PC[8:2], so fetches wrap every 512 bytes.
  localparam int unsigned ImemAddrW        = 7;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned FunctMsb  = 5;
  localparam int unsigned FunctLsb  = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  // All-zero word decodes as sll $0,$0,0.
  localparam word_t Nop = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
  } decoded_t;

  function automatic decoded_t decode_instr(input word_t instr);
    decoded_t d;
    d.opcode   = instr[OpcodeMsb:OpcodeLsb];
    d.rs       = instr[RsMsb:RsLsb];
    d.rt       = instr[RtMsb:RtLsb];
    d.rd       = instr[RdMsb:RdLsb];
    d.funct    = instr[FunctMsb:FunctLsb];
    d.imm_sext = {{16{instr[ImmMsb]}}, instr[ImmMsb:ImmLsb]};
    return d;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: one synchronous write port for program loading and one
// asynchronous read port. The fetch register samples read_data on the same edge
// a write lands, so a same-address fetch sees the old word.
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned Depth = DefaultImemDepth,
  parameter int unsigned AddrW = ImemAddrW
) (
  input  logic             clock,
  input  logic             write_en,
  input  logic [AddrW-1:0] write_addr,
  input  word_t            write_data,
  input  logic [AddrW-1:0] read_addr,
  output word_t            read_data
);

  word_t mem_q [Depth];

  // Program-load write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read_data = mem_q[read_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, branch target adder and IF/ID pipeline register,
// plus combinational field decode of the IF/ID instruction.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = DefaultImemDepth,
  parameter logic [31:0] RESET_PC   = DefaultResetPc
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Stall,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic                 LoadEn,
  input  logic [ImemAddrW-1:0] LoadAddr,
  input  logic [31:0]          LoadData,
  output logic [31:0]          PC,
  output logic                 Valid,
  output logic [31:0]          Instr,
  output logic [31:0]          PCPlus4,
  output logic [5:0]           Opcode,
  output logic [4:0]           ReadReg1,
  output logic [4:0]           ReadReg2,
  output logic [4:0]           Rd,
  output logic [5:0]           Funct,
  output logic [31:0]          Extend32
);

  // Keep the PC word aligned even if a misaligned reset vector is supplied.
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_word;
  logic [31:0] pc_inc;
  logic [31:0] branch_target;
  logic        branch_taken;
  decoded_t    dec;

  instruction_memory #(
    .Depth (IMEM_DEPTH),
    .AddrW (ImemAddrW)
  ) u_imem (
    .clock      (clock),
    .write_en   (LoadEn),
    .write_addr (LoadAddr),
    .write_data (LoadData),
    .read_addr  (pc_q[ImemAddrW+1:2]),
    .read_data  (fetch_word)
  );

  // Next PC and IF/ID contents; Stall holds everything, taken branch flushes.
  always_comb begin
    pc_inc        = pc_q + 32'd4;
    branch_taken  = Branch & Zero & valid_q;
    branch_target = pcplus4_q + {dec.imm_sext[29:0], 2'b00};
    pc_d          = pc_q;
    instr_d       = instr_q;
    pcplus4_d     = pcplus4_q;
    valid_d       = valid_q;
    if (!Stall) begin
      pcplus4_d = pc_inc;
      if (branch_taken) begin
        pc_d    = branch_target;
        instr_d = Nop;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_inc;
        instr_d = fetch_word;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID state; reset overrides stall and any pending branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= ResetPcAligned;
      instr_q   <= Nop;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  // Invalid slots always hold Nop, so decoding instr_q directly is safe.
  assign dec      = decode_instr(instr_q);
  assign PC       = pc_q;
  assign Valid    = valid_q;
  assign Instr    = instr_q;
  assign PCPlus4  = pcplus4_q;
  assign Opcode   = dec.opcode;
  assign ReadReg1 = dec.rs;
  assign ReadReg2 = dec.rt;
  assign Rd       = dec.rd;
  assign Funct    = dec.funct;
  assign Extend32 = dec.imm_sext;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, read-before-write,
// taken/not-taken/stalled branches, fetch wrap and reset in mid-run.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        LoadEn = 1'b0;
  logic [6:0]  LoadAddr = 7'd0;
  logic [31:0] LoadData = 32'd0;
  logic [31:0] PC, Instr, PCPlus4, Extend32;
  logic        Valid;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  ReadReg1, ReadReg2, Rd;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .IMEM_DEPTH (128),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .Stall    (Stall),
    .Branch   (Branch),
    .Zero     (Zero),
    .LoadEn   (LoadEn),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .PC       (PC),
    .Valid    (Valid),
    .Instr    (Instr),
    .PCPlus4  (PCPlus4),
    .Opcode   (Opcode),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .Rd       (Rd),
    .Funct    (Funct),
    .Extend32 (Extend32)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [6:0] addr, input logic [31:0] data);
    LoadEn   = 1'b1;
    LoadAddr = addr;
    LoadData = data;
    tick();
    LoadEn   = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 128; i++) load_word(7'(i), 32'h2000_0000 | 32'(i));
    load_word(7'd0, 32'h0022_1822);
    load_word(7'd1, 32'h0022_2025);
    load_word(7'd2, 32'h8C05_0004);
    load_word(7'd3, 32'hAC05_0008);
    load_word(7'd7, 32'h1000_0077);
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Valid); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", Instr); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got %h want 0", PCPlus4); end
    checks++; if (Opcode !== 6'h0 || Extend32 !== 32'h0) begin
      errors++; $display("FAIL reset_nop_decode got op %h ext %h want 0 0", Opcode, Extend32);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h0022_1822;
    exp_instr[1] = 32'h0022_2025;
    exp_instr[2] = 32'h8C05_0004;
    exp_instr[3] = 32'hAC05_0008;
    reset = 1'b0;
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL seq_first_valid got %b want 0", Valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (Valid !== 1'b1 || Instr !== exp_instr[i] || PCPlus4 !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL seq_%0d got v%b %h %h want v1 %h %h", i, Valid, Instr, PCPlus4, exp_instr[i],
                 32'(4 * (i + 1)));
      end
      if (i == 0) begin
        checks++; if (ReadReg1 !== 5'd1 || ReadReg2 !== 5'd2 || Rd !== 5'd3 || Funct !== 6'h22) begin
          errors++;
          $display("FAIL seq_decode got rs %0d rt %0d rd %0d fn %h want 1 2 3 22", ReadReg1, ReadReg2,
                   Rd, Funct);
        end
        checks++; if (Extend32 !== 32'h0000_1822 || Opcode !== 6'h0) begin
          errors++; $display("FAIL seq_ext got %h op %h want 00001822 00", Extend32, Opcode);
        end
      end
      if (i == 2) begin
        checks++; if (Opcode !== 6'h23 || Extend32 !== 32'h4) begin
          errors++; $display("FAIL seq_lw_decode got op %h ext %h want 23 4", Opcode, Extend32);
        end
      end
    end
    checks++; if (PC !== 32'h10) begin errors++; $display("FAIL seq_pc got %h want 10", PC); end
  endtask

  task automatic test_read_before_write();
    restart();
    LoadEn   = 1'b1;
    LoadAddr = 7'd0;
    LoadData = 32'hDEAD_BEEF;
    tick();
    LoadEn = 1'b0;
    checks++; if (Instr !== 32'h0022_1822) begin errors++; $display("FAIL rbw_old got %h want 00221822", Instr); end
    checks++; if (PC !== 32'h4) begin errors++; $display("FAIL rbw_pc got %h want 4", PC); end
    restart();
    tick();
    checks++; if (Instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_new got %h want deadbeef", Instr); end
    reset = 1'b1;
    load_word(7'd0, 32'h0022_1822);
    load_word(7'd3, 32'h1022_0003);
  endtask

  task automatic test_branch_taken_and_wrap();
    restart();
    repeat (4) tick();
    checks++; if (Instr !== 32'h1022_0003 || PCPlus4 !== 32'h10) begin
      errors++; $display("FAIL br_setup got %h %h want 10220003 10", Instr, PCPlus4);
    end
    Branch = 1'b1;
    Zero   = 1'b1;
    tick();
    Branch = 1'b0;
    Zero   = 1'b0;
    checks++; if (PC !== 32'h1C || Valid !== 1'b0 || Instr !== 32'h0) begin
      errors++; $display("FAIL br_taken got pc %h v%b %h want 1c v0 0", PC, Valid, Instr);
    end
    tick();
    checks++; if (Instr !== 32'h1000_0077 || Valid !== 1'b1 || PCPlus4 !== 32'h20) begin
      errors++; $display("FAIL br_target got %h v%b %h want 10000077 v1 20", Instr, Valid, PCPlus4);
    end
    Branch = 1'b1;
    Zero   = 1'b1;
    tick();
    Branch = 1'b0;
    Zero   = 1'b0;
    checks++; if (PC !== 32'h1FC) begin errors++; $display("FAIL wrap_branch got %h want 1fc", PC); end
    tick();
    checks++; if (Instr !== 32'h2000_007F || PC !== 32'h200) begin
      errors++; $display("FAIL wrap_last got %h pc %h want 2000007f 200", Instr, PC);
    end
    tick();
    checks++; if (Instr !== 32'h0022_1822 || PCPlus4 !== 32'h204) begin
      errors++; $display("FAIL wrap_first got %h %h want 00221822 204", Instr, PCPlus4);
    end
  endtask

  task automatic test_not_taken();
    restart();
    repeat (4) tick();
    Branch = 1'b1;
    Zero   = 1'b0;
    tick();
    Branch = 1'b0;
    checks++; if (PC !== 32'h14 || Valid !== 1'b1 || Instr !== 32'h2000_0004) begin
      errors++; $display("FAIL not_taken got pc %h v%b %h want 14 v1 20000004", PC, Valid, Instr);
    end
  endtask

  task automatic test_stall_branch();
    restart();
    repeat (4) tick();
    Branch = 1'b1;
    Zero   = 1'b1;
    Stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PC !== 32'h10 || Instr !== 32'h1022_0003 || Valid !== 1'b1) begin
        errors++; $display("FAIL stall_%0d got pc %h %h v%b want 10 10220003 v1", i, PC, Instr, Valid);
      end
    end
    Stall = 1'b0;
    tick();
    checks++; if (PC !== 32'h1C || Valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got pc %h v%b want 1c v0", PC, Valid);
    end
    tick();
    Branch = 1'b0;
    Zero   = 1'b0;
    checks++; if (PC !== 32'h20 || Valid !== 1'b1 || Instr !== 32'h1000_0077) begin
      errors++; $display("FAIL stall_once got pc %h v%b %h want 20 v1 10000077", PC, Valid, Instr);
    end
  endtask

  task automatic test_negative_offset();
    reset = 1'b1;
    load_word(7'd1, 32'h1000_FFFE);
    restart();
    repeat (2) tick();
    checks++; if (Extend32 !== 32'hFFFF_FFFE || PCPlus4 !== 32'h8) begin
      errors++; $display("FAIL neg_setup got %h %h want fffffffe 8", Extend32, PCPlus4);
    end
    Branch = 1'b1;
    Zero   = 1'b1;
    tick();
    Branch = 1'b0;
    Zero   = 1'b0;
    checks++; if (PC !== 32'h0 || Valid !== 1'b0) begin
      errors++; $display("FAIL neg_target got pc %h v%b want 0 v0", PC, Valid);
    end
  endtask

  task automatic test_reset_mid_run();
    restart();
    repeat (16) tick();
    checks++; if (PC !== 32'h40 || Instr !== 32'h2000_000F) begin
      errors++; $display("FAIL mid_setup got pc %h %h want 40 2000000f", PC, Instr);
    end
    Stall  = 1'b1;
    Branch = 1'b1;
    Zero   = 1'b1;
    reset  = 1'b1;
    tick();
    checks++; if (PC !== 32'h0 || Valid !== 1'b0 || Instr !== 32'h0 || PCPlus4 !== 32'h0) begin
      errors++; $display("FAIL mid_reset got pc %h v%b %h %h want 0 v0 0 0", PC, Valid, Instr, PCPlus4);
    end
    reset  = 1'b0;
    Stall  = 1'b0;
    Branch = 1'b0;
    Zero   = 1'b0;
    tick();
    checks++; if (Instr !== 32'h0022_1822 || Valid !== 1'b1) begin
      errors++; $display("FAIL mid_mem0 got %h v%b want 00221822 v1", Instr, Valid);
    end
    tick();
    checks++; if (Instr !== 32'h1000_FFFE) begin errors++; $display("FAIL mid_mem1 got %h want 1000fffe", Instr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_read_before_write();
    test_branch_taken_and_wrap();
    test_not_taken();
    test_stall_branch();
    test_negative_offset();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
